bmf_h_stream_decoder: RTL

//  Streaming decompressor for BMF-partitioned approximate circuits: takes K-bit factor vectors
//  (k) produced by a w-side compressor and expands them to M-bit outputs via a programmable
//  K x M basis matrix H, under the Boolean (OR-of-AND) or GF(2) (XOR-of-AND) semiring.

---
 rtl/bmf_h_stream_decoder.sv | 91 +++++++++
 1 files changed

// File: rtl/bmf_h_stream_decoder.sv
// Streaming BMF decompressor: expands K-bit factor vectors into M-bit outputs through a
// programmable K x M basis matrix H, using OR-of-AND or XOR-of-AND, with a 1-deep output register.
module bmf_h_stream_decoder #(
    parameter int K        = 5,
    parameter int M        = 6,
    parameter int XOR_MODE = 0,
    parameter int CNT_W    = 16,
    localparam int ROW_W   = (K > 1) ? $clog2(K) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [ROW_W-1:0] cfg_row,
    input  logic [M-1:0]     cfg_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [K-1:0]     s_k,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [M-1:0]     m_out,
    output logic [CNT_W-1:0] acc_cnt
);

    logic [M-1:0]     h_q [K];
    logic             m_valid_q;
    logic [M-1:0]     m_out_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [CNT_W-1:0] acc_cnt_d;
    logic [M-1:0]     prod_d;
    logic             accept;

    // Default basis shifts the factors up by one: out0 = 0, out[i+1] = k[i].
    function automatic logic [M-1:0] defaultRow(input int row);
        logic [M-1:0] r;
        for (int j = 0; j < M; j++) begin
            r[j] = (j == row + 1);
        end
        return r;
    endfunction

    assign s_ready   = ~m_valid_q | m_ready;
    assign accept    = s_valid & s_ready;
    assign acc_cnt_d = acc_cnt_q + CNT_W'(1);

    always_comb begin
        prod_d = '0;
        for (int j = 0; j < M; j++) begin
            for (int i = 0; i < K; i++) begin
                if (XOR_MODE != 0) begin
                    prod_d[j] = prod_d[j] ^ (s_k[i] & h_q[i][j]);
                end else begin
                    prod_d[j] = prod_d[j] | (s_k[i] & h_q[i][j]);
                end
            end
        end
    end

    // Row writes land at the clock edge, so an accept in the same cycle still sees the old H.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                h_q[i] <= defaultRow(i);
            end
        end else begin
            for (int i = 0; i < K; i++) begin
                if (cfg_we && (cfg_row == ROW_W'(i))) begin
                    h_q[i] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_out_q   <= '0;
            acc_cnt_q <= '0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_out_q   <= prod_d;
            acc_cnt_q <= acc_cnt_d;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_out   = m_out_q;
    assign acc_cnt = acc_cnt_q;

endmodule
